// File: rtl/trng_pkg.sv
// trng_pkg: shared types and widths for the TRNG post-processor
package trng_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAIL} state_t;
  typedef enum logic {PAIR_A, PAIR_B} pair_t;
  localparam int BYTE_W = 8;
  localparam int BIT_CNT_W = 3;
  localparam int DIV_W = 8;
  localparam int REP_W = 8;
endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: von Neumann pair debiaser, emits the first bit of each unequal pair
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic bit_in,
  input  logic flush,
  output logic out_valid,
  output logic out_bit
);
  pair_t pair;
  logic first;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pair <= PAIR_A;
      first <= 1'b0;
    end else if (tick) begin
      pair <= pair == PAIR_A ? PAIR_B : PAIR_A;
      first <= pair == PAIR_A ? bit_in : first;
    end
  end
  assign out_valid = tick && pair == PAIR_B && first != bit_in;
  assign out_bit = first;
endmodule

// File: rtl/trng_postproc.sv
// trng_postproc: sync, decimate, health-test, debias and byte-pack a raw entropy bit
module trng_postproc
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT = 32,
  parameter bit VN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_in,
  input  logic              en,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              health_fail,
  input  logic              clear_fail,
  output logic              overflow
);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);
  state_t state, state_n;
  logic sync1, raw_s, last_s;
  logic [DIV_W-1:0] div_cnt;
  logic [REP_W-1:0] rep_cnt, rep_n;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-2:0] sr;
  logic [BYTE_W-1:0] byte_n;
  logic active, run, tick, fire, emit, ebit, byte_done, load;
  assign active = state != ST_IDLE;
  assign run = state == ST_RUN;
  assign tick = active && div_cnt == DIV_LAST;
  // rep_cnt of 0 marks "no previous sample", so the next tick always restarts at 1
  assign rep_n = (rep_cnt == '0 || raw_s != last_s) ? REP_W'(1)
               : rep_cnt == REP_MAX ? REP_MAX : rep_cnt + 1'b1;
  assign fire = tick && rep_n == REP_MAX && rep_cnt != REP_MAX;
  assign byte_n = {sr, ebit};
  assign byte_done = emit && bit_cnt == '1;
  assign load = byte_done && (!data_valid || data_ready);
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = en ? ST_RUN : ST_IDLE;
      ST_RUN:  state_n = fire ? ST_FAIL : en ? ST_RUN : ST_IDLE;
      ST_FAIL: state_n = clear_fail && !fire ? (en ? ST_RUN : ST_IDLE) : ST_FAIL;
      default: state_n = ST_IDLE;
    endcase
  end
  generate
    if (VN_EN) begin : g_vn
      trng_vn_debias u_vn (
        .clk(clk),
        .rst(rst),
        .tick(tick && run),
        .bit_in(raw_s),
        .flush(!run),
        .out_valid(emit),
        .out_bit(ebit)
      );
    end else begin : g_raw
      assign emit = tick && run;
      assign ebit = raw_s;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sync1 <= 1'b0;
      raw_s <= 1'b0;
      last_s <= 1'b0;
      div_cnt <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      health_fail <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      sync1 <= raw_in;
      raw_s <= sync1;
      div_cnt <= !active || tick ? '0 : div_cnt + 1'b1;
      rep_cnt <= clear_fail || !active ? '0 : tick ? rep_n : rep_cnt;
      last_s <= tick ? raw_s : last_s;
      health_fail <= fire || (health_fail && !clear_fail);
      bit_cnt <= state == ST_FAIL ? '0 : emit ? bit_cnt + 1'b1 : bit_cnt;
      sr <= state == ST_FAIL ? '0 : emit ? byte_n[BYTE_W-2:0] : sr;
      data_valid <= load || (data_valid && !data_ready);
      data_out <= load ? byte_n : data_out;
      overflow <= overflow || (byte_done && !load);
    end
  end
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: scoreboard bench driving sample streams into trng_postproc against a sample-level model
module tb_trng_postproc;
  localparam int DIV = 4;
  localparam int REP = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic raw_in = 1'b0, en = 1'b0, data_ready = 1'b1, clear_fail = 1'b0;
  logic [7:0] data_out;
  logic data_valid, health_fail, overflow;
  logic raw2 = 1'b0, en2 = 1'b0;
  logic [7:0] data_out2;
  logic valid2, hf2, ovf2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  trng_postproc #(.SAMPLE_DIV(DIV), .REP_LIMIT(REP), .VN_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .en(en), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .health_fail(health_fail),
    .clear_fail(clear_fail), .overflow(overflow)
  );

  trng_postproc #(.SAMPLE_DIV(1), .REP_LIMIT(REP), .VN_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .raw_in(raw2), .en(en2), .data_out(data_out2),
    .data_valid(valid2), .data_ready(1'b1), .health_fail(hf2),
    .clear_fail(1'b0), .overflow(ovf2)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample-level reference model: one call per sample tick
  logic [7:0] exp_q[$];
  bit m_bits[$];
  int m_rep = 0;
  bit m_last, m_have, m_first, m_fail, m_hold, m_busy, exp_ovf;

  function automatic void m_emit(bit b);
    logic [7:0] v;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      v = '0;
      foreach (m_bits[i]) v = {v[6:0], m_bits[i]};
      m_bits.delete();
      if (m_hold && m_busy) exp_ovf = 1'b1;
      else begin
        exp_q.push_back(v);
        m_busy = m_hold;
      end
    end
  endfunction

  function automatic void m_tick(bit b);
    int prev = m_rep;
    m_rep = (m_rep == 0 || b != m_last) ? 1 : (m_rep < REP ? m_rep + 1 : REP);
    m_last = b;
    if (!m_fail) begin
      if (!m_have) begin
        m_have = 1'b1;
        m_first = b;
      end else begin
        m_have = 1'b0;
        if (m_first != b) m_emit(m_first);
      end
    end
    if (m_rep == REP && prev != REP) begin
      m_fail = 1'b1;
      m_have = 1'b0;
      m_bits.delete();
    end
  endfunction

  // Each sample occupies one DIV-cycle period; an optional clear pulse lands mid-period
  task automatic sample(logic b, logic clr = 1'b0);
    raw_in = b;
    if (clr) begin
      m_rep = 0;
      m_fail = 1'b0;
    end
    m_tick(b);
    @(negedge clk);
    clear_fail = clr;
    @(negedge clk);
    clear_fail = 1'b0;
    repeat (DIV - 2) @(negedge clk);
  endtask

  task automatic send_bits(logic [7:0] v, int n);
    for (int i = n - 1; i >= 0; i--) begin
      sample(v[i]);
      sample(!v[i]);
    end
  endtask

  task automatic stop();
    en = 1'b0;
    m_have = 1'b0;
    m_rep = 0;
    @(negedge clk);
  endtask

  task automatic set_ready(logic v);
    @(posedge clk);
    #1 data_ready = v;
    @(negedge clk);
  endtask

  // Monitor: pops an expected byte on every handshake, checks hold stability under stall
  logic stall = 1'b0;
  logic [7:0] held = '0, last_byte = '0;
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", data_out);
      end else check("byte", data_out, exp_q.pop_front());
      last_byte = data_out;
    end
    if (stall && data_valid) check("hold_stable", data_out, held);
    stall = data_valid && !data_ready;
    held = data_out;
  end

  initial begin
    logic [7:0] seq;
    repeat (3) begin
      @(negedge clk);
      raw_in = !raw_in;
      raw2 = !raw2;
    end
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_hf", health_fail, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    raw_in = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_hf", health_fail, 0);
    check("idle_valid", data_valid, 0);

    // VN off, SAMPLE_DIV=1: raw stream 1,1,0,0,1,0,1,0
    seq = 8'hCA;
    for (int k = 0; k < 8; k++) begin
      raw2 = seq[7-k];
      if (k == 1) en2 = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    en2 = 1'b0;
    check("raw_before", valid2, 0);
    @(negedge clk);
    check("raw_valid", valid2, 1);
    check("raw_byte", data_out2, 8'hCA);
    @(negedge clk);
    check("raw_clear", valid2, 0);

    // Debias: pairs give 0xA5, valid one cycle after the 16th tick
    en = 1'b1;
    send_bits(8'hA5, 8);
    check("vn_before", data_valid, 0);
    stop();
    check("vn_valid", data_valid, 1);
    check("vn_byte", data_out, 8'hA5);
    @(negedge clk);
    check("vn_clear", data_valid, 0);

    // Same byte with 00/11 pairs in between
    en = 1'b1;
    seq = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      sample(seq[i]);
      sample(!seq[i]);
      sample(i[0]);
      sample(i[0]);
    end
    stop();
    repeat (3) @(negedge clk);
    check("vn_pad_byte", last_byte, 8'hA5);
    check("vn_pad_drain", exp_q.size(), 0);

    // Health: partial bits, then 32 identical samples
    en = 1'b1;
    send_bits(8'h05, 3);
    repeat (31) sample(1'b1);
    sample(1'b1);
    check("hf_before", health_fail, 0);
    fork
      begin
        @(negedge clk);
        check("hf_set", health_fail, 1);
      end
    join_none
    sample(1'b1);
    sample(1'b0);
    sample(1'b0);
    sample(1'b1);
    check("hf_sticky", health_fail, 1);
    check("hf_no_valid", data_valid, 0);
    sample(1'b1, 1'b1);
    check("hf_cleared", health_fail, 0);
    sample(1'b1);
    send_bits(8'h69, 8);
    stop();
    repeat (3) @(negedge clk);
    check("hf_fresh_byte", last_byte, 8'h69);

    // Backpressure: 0x3C held, 0xFF dropped
    set_ready(1'b0);
    m_hold = 1'b1;
    en = 1'b1;
    send_bits(8'h3C, 8);
    send_bits(8'hFF, 8);
    stop();
    check("bp_valid", data_valid, 1);
    check("bp_byte", data_out, 8'h3C);
    check("bp_ovf", overflow, exp_ovf);
    set_ready(1'b1);
    m_hold = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    check("bp_consumed", last_byte, 8'h3C);
    en = 1'b1;
    send_bits(8'h73, 7);
    stop();
    repeat (2) @(negedge clk);
    check("bp_seven_bits", data_valid, 0);
    en = 1'b1;
    send_bits(8'h01, 1);
    stop();
    repeat (2) @(negedge clk);
    check("bp_next_byte", last_byte, 8'hE7);

    // en dropped mid-pair: pair discarded, partial bits kept
    en = 1'b1;
    send_bits(8'h06, 3);
    sample(1'b1);
    stop();
    en = 1'b1;
    send_bits(8'h02, 2);
    send_bits(8'h03, 3);
    stop();
    repeat (3) @(negedge clk);
    check("en_drop_byte", last_byte, 8'hD3);

    // Randomized sample streams, runs capped well below the repetition limit
    for (int r = 0; r < 6; r++) begin
      logic b, p;
      int streak;
      p = 1'b0;
      streak = 0;
      en = 1'b1;
      repeat ($urandom_range(10, 60)) begin
        b = 1'($urandom);
        if (streak >= 6 && b == p) b = !p;
        streak = (b == p) ? streak + 1 : 1;
        p = b;
        sample(b);
      end
      stop();
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) send_bits(8'($urandom), 8);
    stop();
    repeat (10) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    check("final_ovf", overflow, exp_ovf);
    check("final_hf", health_fail, 0);
    check("dut2_hf", hf2, 0);
    check("dut2_ovf", ovf2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
